// File: rtl/nn_result_streamer.sv
`default_nettype none
// =============================================================================
// nn_result_streamer - reads a result vector from neuron RAM and streams it to
// a valid/ready/last host. Optional macro: NN_RESULT_STREAMER_ARGMAX_EN. Rev 1.0
// =============================================================================
module nn_result_streamer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              finished,
  input  logic [ADDR_W-1:0] result_base_address,
  input  logic [7:0]        result_word_count,
  output logic [ADDR_W-1:0] ram_read_adr,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef NN_RESULT_STREAMER_ARGMAX_EN
  ,
  output logic [7:0]        argmax_index,
  output logic [DATA_W-1:0] argmax_value
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   c_depth    = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_finished_d;
  logic [7:0]          r_count;
  logic [7:0]          r_issued;
  logic [7:0]          r_sent;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_ram_adr;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_fifo_count;

  logic                w_start;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_valid;
  logic                w_last;
  logic [CNT_W:0]      w_used;
  logic [DATA_W-1:0]   w_head;
  logic [PTR_W-1:0]    w_wr_next;
  logic [PTR_W-1:0]    w_rd_next;

  assign w_start   = (r_state == S_IDLE) & finished & ~r_finished_d;
  // Credit rule: a read is only issued if its data is guaranteed a FIFO slot.
  assign w_used    = {1'b0, r_fifo_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue   = (r_state == S_STREAM) & (r_issued < r_count) & (w_used < c_depth);
  assign w_push    = r_inflight;
  assign w_valid   = (r_fifo_count != '0);
  assign w_pop     = w_valid & out_ready;
  assign w_last    = w_valid & (r_sent == (r_count - 8'd1));
  assign w_head    = r_mem[r_rd_ptr];
  assign w_wr_next = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_next = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = (result_word_count == 8'd0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_pop & w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!finished) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_finished_d <= 1'b0;
      r_count      <= 8'd0;
      r_issued     <= 8'd0;
      r_sent       <= 8'd0;
      r_inflight   <= 1'b0;
      r_ram_adr    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      r_finished_d <= finished;
      r_inflight   <= w_issue;
      if (w_start) begin
        r_count   <= result_word_count;
        r_issued  <= 8'd0;
        r_sent    <= 8'd0;
        r_ram_adr <= result_base_address;
      end
      // The address stops on the last issued word rather than running one past.
      if (w_issue) begin
        r_issued <= r_issued + 8'd1;
        if ((r_issued + 8'd1) < r_count) begin
          r_ram_adr <= r_ram_adr + ADDR_W'(1);
        end
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= ram_read_data;
        r_wr_ptr        <= w_wr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
        r_sent   <= r_sent + 8'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

`ifdef NN_RESULT_STREAMER_ARGMAX_EN
  logic [7:0]        r_argmax_index;
  logic [DATA_W-1:0] r_argmax_value;

  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_argmax_index <= 8'd0;
      r_argmax_value <= '0;
    end else if (w_pop) begin
      if ((r_sent == 8'd0) || ($signed(w_head) > $signed(r_argmax_value))) begin
        r_argmax_index <= r_sent;
        r_argmax_value <= w_head;
      end
    end
  end

  assign argmax_index = r_argmax_index;
  assign argmax_value = r_argmax_value;
`endif

  assign ram_read_adr = r_ram_adr;
  assign out_valid    = w_valid;
  assign out_data     = w_valid ? w_head : '0;
  assign out_last     = w_last;
  assign busy         = (r_state == S_STREAM);
  assign done         = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nn_result_streamer.sv
`default_nettype none
// tb_nn_result_streamer - scoreboard bench: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_nn_result_streamer;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              finished;
  logic [ADDR_W-1:0] result_base_address;
  logic [7:0]        result_word_count;
  logic [ADDR_W-1:0] ram_read_adr;
  logic [DATA_W-1:0] ram_read_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
`ifdef NN_RESULT_STREAMER_ARGMAX_EN
  logic [7:0]        argmax_index;
  logic [DATA_W-1:0] argmax_value;
  logic [7:0]        exp_amax_idx;
  logic [7:0]        exp_amax_val;
`endif

  nn_result_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .finished           (finished),
    .result_base_address(result_base_address),
    .result_word_count  (result_word_count),
    .ram_read_adr       (ram_read_adr),
    .ram_read_data      (ram_read_data),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_last           (out_last),
    .busy               (busy),
    .done               (done)
`ifdef NN_RESULT_STREAMER_ARGMAX_EN
    ,
    .argmax_index       (argmax_index),
    .argmax_value       (argmax_value)
`endif
  );

  always #5 clk = ~clk;

  // Neuron RAM model: one-cycle registered read.
  logic [7:0] ram [256];
  always @(posedge clk) ram_read_data <= ram[ram_read_adr];

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      mon_e;
  int         checks = 0;
  int         errors = 0;
  int         ready_mode = 0;
  int         rcnt = 0;
  int         accepted = 0;
  bit         mon_en = 1'b1;
  bit         done_due = 1'b0;
  bit         stalled = 1'b0;
  logic [7:0] stall_data;
  bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = pat[rcnt % 6]; rcnt++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (done_due) begin
        check("done_after_last", done, 1);
        check("busy_after_last", busy, 0);
        done_due = 1'b0;
      end
      if (stalled) begin
        check("stall_valid_held", out_valid, 1);
        if (out_valid) check("stall_data_stable", out_data, stall_data);
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h, no beat expected at %0t", out_data, $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("beat_data", out_data, mon_e.data);
            check("beat_last", out_last, mon_e.last);
            accepted++;
            if (mon_e.last) done_due = 1'b1;
          end
        end else begin
          stalled    = 1'b1;
          stall_data = out_data;
        end
      end
    end
  end

  task automatic start_vector(input logic [7:0] b, input logic [7:0] c, input int mode);
    beat_t      e;
    logic [7:0] a;
    ready_mode = mode;
    @(negedge clk);
    result_base_address = b;
    result_word_count   = c;
    finished            = 1'b1;
`ifdef NN_RESULT_STREAMER_ARGMAX_EN
    exp_amax_idx = 8'd0;
    exp_amax_val = 8'd0;
`endif
    for (int i = 0; i < int'(c); i++) begin
      a      = b + 8'(i);
      e.data = ram[a];
      e.last = (i == int'(c) - 1);
      exp_q.push_back(e);
`ifdef NN_RESULT_STREAMER_ARGMAX_EN
      if (i == 0 || $signed(e.data) > $signed(exp_amax_val)) begin
        exp_amax_idx = 8'(i);
        exp_amax_val = e.data;
      end
`endif
    end
  endtask

  task automatic run_vector(input logic [7:0] b, input logic [7:0] c, input int mode, input bit drop_fin);
    int lat;
    int n;
    start_vector(b, c, mode);
    @(posedge clk);
    #1;
    if (c == 8'd0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_valid", out_valid, 0);
      repeat (3) begin
        @(posedge clk);
        #1;
        check("zero_busy_stays", busy, 0);
      end
    end else begin
      check("start_busy", busy, 1);
      result_base_address = ~b;
      result_word_count   = c + 8'd7;
      lat = 0;
      while (lat < 10) begin
        @(posedge clk);
        lat++;
        #1;
        if (out_valid) break;
      end
      check("first_valid_latency", lat, 2);
      if (drop_fin) finished = 1'b0;
      n = 0;
      while (!done && n < 3000) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("done_reached", done, 1);
      check("queue_drained", exp_q.size(), 0);
    end
`ifdef NN_RESULT_STREAMER_ARGMAX_EN
    check("argmax_index", argmax_index, exp_amax_idx);
    check("argmax_value", argmax_value, exp_amax_val);
`endif
    finished = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("idle_done_low", done, 0);
    check("idle_busy_low", busy, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
  endtask

  initial begin
    int n;
    int a0;
    reset = 1'b1;
    finished = 1'b0;
    result_base_address = '0;
    result_word_count = '0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_adr", ram_read_adr, 0);
    reset = 1'b0;

    ram[20] = 8'h11; ram[21] = 8'h22; ram[22] = 8'h33; ram[23] = 8'h44;
    run_vector(8'd20, 8'd4, 0, 1'b0);
    rcnt = 0;
    run_vector(8'd20, 8'd4, 1, 1'b0);
    run_vector(8'd9, 8'd0, 0, 1'b0);
    ram[8'hFE] = 8'hA1; ram[8'hFF] = 8'hB2; ram[8'h00] = 8'hC3;
    run_vector(8'hFE, 8'd3, 0, 1'b0);

    // Reset after three accepted beats, then restart the same vector.
    fill_random();
    start_vector(8'd40, 8'd8, 0);
    a0 = accepted;
    n = 0;
    while ((accepted - a0) < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("three_beats_seen", accepted - a0, 3);
    @(posedge clk);
    mon_en = 1'b0;
    #1;
    reset = 1'b1;
    finished = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    stalled = 1'b0;
    done_due = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    run_vector(8'd40, 8'd8, 0, 1'b0);

    ram[50] = 8'h05; ram[51] = 8'hF0; ram[52] = 8'h7F; ram[53] = 8'h7F;
    run_vector(8'd50, 8'd4, 2, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_vector(8'($urandom), 8'($urandom_range(1, 40)), 2, 1'($urandom_range(0, 1)));
    end
    fill_random();
    run_vector(8'($urandom), 8'd255, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
